// File: rtl/regfile_wb_merge.sv
// rtl/regfile_wb_merge.sv - write-back merge of pipeline and long-latency returns onto two RF write ports
//
// Purpose:
//   Port 1 carries the in-order pipeline write-back straight through.
//   Long-latency returns (remote loads, divider, FPU-to-int) are queued in a
//   small circular FIFO and drained one per cycle onto port 2. The head is
//   held back whenever the pipeline writes the same register that cycle.
//
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   pipe_v_i/addr_i/data_i             pipeline write-back (never stalled)
//   ret_v_i/addr_i/data_i, ret_ready_o long-latency return handshake
//   w_v_o/w_addr_o/w_data_o            register file write port 1
//   w_v_2_o/w_addr_2_o/w_data_2_o      register file write port 2
//   ret_count_o, ret_empty_o           return buffer occupancy for issue/fence
module regfile_wb_merge #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int fifo_els_p        = 4,
  parameter bit x0_tied_to_zero_p = 1'b1,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp   = $clog2(fifo_els_p + 1),
  localparam int ptr_width_lp     = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      pipe_v_i,
  input  logic [addr_width_lp-1:0]  pipe_addr_i,
  input  logic [width_p-1:0]        pipe_data_i,
  input  logic                      ret_v_i,
  input  logic [addr_width_lp-1:0]  ret_addr_i,
  input  logic [width_p-1:0]        ret_data_i,
  output logic                      ret_ready_o,
  output logic                      w_v_o,
  output logic [addr_width_lp-1:0]  w_addr_o,
  output logic [width_p-1:0]        w_data_o,
  output logic                      w_v_2_o,
  output logic [addr_width_lp-1:0]  w_addr_2_o,
  output logic [width_p-1:0]        w_data_2_o,
  output logic [count_width_lp-1:0] ret_count_o,
  output logic                      ret_empty_o
);

  logic [addr_width_lp-1:0]  addr_mem [fifo_els_p];
  logic [width_p-1:0]        data_mem [fifo_els_p];
  logic [ptr_width_lp-1:0]   rd_ptr, wr_ptr;
  logic [count_width_lp-1:0] count;
  logic                      empty, conflict, drop, enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Port 1: straight pass-through; x0 filtering is left to the register file.
  assign w_v_o    = pipe_v_i & ~reset_i;
  assign w_addr_o = pipe_addr_i;
  assign w_data_o = pipe_data_i;

  // Ready comes only from registered state, so it never loops back through ret_v_i.
  assign empty       = (count == '0);
  assign ret_ready_o = ~reset_i & (count != count_width_lp'(fifo_els_p));

  // Returns to x0 are consumed by the handshake but never occupy a slot.
  assign drop = x0_tied_to_zero_p & (ret_addr_i == '0);
  assign enq  = ret_v_i & ret_ready_o & ~drop;

  // Head is always presented; valid is suppressed when the pipeline targets
  // the same register so the two ports never collide.
  assign w_addr_2_o = addr_mem[rd_ptr];
  assign w_data_2_o = data_mem[rd_ptr];
  assign conflict   = pipe_v_i & (pipe_addr_i == w_addr_2_o);
  assign w_v_2_o    = ~reset_i & ~empty & ~conflict;
  assign deq        = w_v_2_o;

  assign ret_count_o = count;
  assign ret_empty_o = empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_next(wr_ptr);
      if (deq) rd_ptr <= ptr_next(rd_ptr);
      count <= count + count_width_lp'(enq) - count_width_lp'(deq);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem[wr_ptr] <= ret_addr_i;
      data_mem[wr_ptr] <= ret_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_wb_merge.sv
// tb/tb_regfile_wb_merge.sv - scoreboard bench for regfile_wb_merge
module tb_regfile_wb_merge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        pipe_v_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        ret_v_i;
  logic [4:0]  ret_addr_i;
  logic [31:0] ret_data_i;
  logic        ret_ready_o;
  logic        w_v_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        w_v_2_o;
  logic [4:0]  w_addr_2_o;
  logic [31:0] w_data_2_o;
  logic [2:0]  ret_count_o;
  logic        ret_empty_o;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_wb_merge #(
    .width_p(32), .els_p(32), .fifo_els_p(4), .x0_tied_to_zero_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .ret_v_i(ret_v_i), .ret_addr_i(ret_addr_i), .ret_data_i(ret_data_i),
    .ret_ready_o(ret_ready_o),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .w_v_2_o(w_v_2_o), .w_addr_2_o(w_addr_2_o), .w_data_2_o(w_data_2_o),
    .ret_count_o(ret_count_o), .ret_empty_o(ret_empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every port-2 write must match the oldest outstanding return.
  always @(negedge clk) begin
    if (reset_i) begin
      exp_q.delete();
    end else if (w_v_2_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL port2_unexpected: got addr %0d data 0x%0h expected no write", w_addr_2_o, w_data_2_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("port2_addr", {27'd0, w_addr_2_o}, {27'd0, e[36:32]});
        check("port2_data", w_data_2_o, e[31:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at negedge with ret_v_i asserted: waits (bounded) for ready, logs the expectation.
  task automatic accept_ret(input string name);
    int n;
    n = 0;
    while (!ret_ready_o && n < 20) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, ret_ready_o}, 32'd1);
    if (ret_ready_o && ret_addr_i != 5'd0) exp_q.push_back({ret_addr_i, ret_data_i});
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ret_empty_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, ret_empty_o}, 32'd1);
  endtask

  logic [4:0]  wrap_addr [11] = '{5'd1, 5'd31, 5'd17, 5'd4, 5'd22, 5'd9, 5'd30, 5'd12, 5'd5, 5'd27, 5'd2};

  initial begin
    reset_i = 1'b1; pipe_v_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 32'h1;
    ret_v_i = 1'b0; ret_addr_i = '0; ret_data_i = '0;

    // Reset values
    next_cycle();
    @(negedge clk);
    check("rst_ready", {31'd0, ret_ready_o}, 32'd0);
    check("rst_w_v", {31'd0, w_v_o}, 32'd0);
    check("rst_w_v_2", {31'd0, w_v_2_o}, 32'd0);
    check("rst_count", {29'd0, ret_count_o}, 32'd0);
    check("rst_empty", {31'd0, ret_empty_o}, 32'd1);
    next_cycle();
    reset_i = 1'b0; pipe_v_i = 1'b0;

    // Idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ret_ready_o}, 32'd1);
      check("idle_empty", {31'd0, ret_empty_o}, 32'd1);
      check("idle_count", {29'd0, ret_count_o}, 32'd0);
      check("idle_w_v_2", {31'd0, w_v_2_o}, 32'd0);
    end

    // Pipeline pass-through
    next_cycle();
    pipe_v_i = 1'b1; pipe_addr_i = 5'd5; pipe_data_i = 32'hDEAD_BEEF;
    #1;
    check("pass_v", {31'd0, w_v_o}, 32'd1);
    check("pass_addr", {27'd0, w_addr_o}, 32'd5);
    check("pass_data", w_data_o, 32'hDEAD_BEEF);
    check("pass_no_p2", {31'd0, w_v_2_o}, 32'd0);
    next_cycle();
    pipe_v_i = 1'b0;

    // Single return: accepted in N, written and counted in N+1, gone in N+2
    ret_v_i = 1'b1; ret_addr_i = 5'd7; ret_data_i = 32'h1234;
    @(negedge clk);
    accept_ret("single_ready");
    next_cycle();
    ret_v_i = 1'b0;
    @(negedge clk);
    check("single_w_v_2", {31'd0, w_v_2_o}, 32'd1);
    check("single_count1", {29'd0, ret_count_o}, 32'd1);
    @(negedge clk);
    check("single_count0", {29'd0, ret_count_o}, 32'd0);

    // Fill and backpressure: pipe hogs addr 3 so nothing drains
    next_cycle();
    pipe_v_i = 1'b1; pipe_addr_i = 5'd3; pipe_data_i = 32'h3333;
    for (int i = 0; i < 4; i++) begin
      ret_v_i = 1'b1; ret_addr_i = 5'd3; ret_data_i = 32'h100 + i;
      @(negedge clk);
      check("fill_ready", {31'd0, ret_ready_o}, 32'd1);
      if (ret_ready_o) exp_q.push_back({ret_addr_i, ret_data_i});
      next_cycle();
    end
    ret_data_i = 32'h104;
    @(negedge clk);
    check("full_ready", {31'd0, ret_ready_o}, 32'd0);
    check("full_count", {29'd0, ret_count_o}, 32'd4);
    check("full_w_v_2", {31'd0, w_v_2_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("full_hold_count", {29'd0, ret_count_o}, 32'd4);
    next_cycle();
    pipe_v_i = 1'b0;
    @(negedge clk);
    check("drain_start_v2", {31'd0, w_v_2_o}, 32'd1);
    check("drain_start_ready", {31'd0, ret_ready_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    accept_ret("fifth_ready");
    next_cycle();
    ret_v_i = 1'b0;
    wait_empty("fill_drained");

    // Conflict hold on head addr 9
    next_cycle();
    pipe_v_i = 1'b1; pipe_addr_i = 5'd9; pipe_data_i = 32'h9999;
    ret_v_i = 1'b1; ret_addr_i = 5'd9; ret_data_i = 32'h0909;
    @(negedge clk);
    accept_ret("conf_ready");
    next_cycle();
    ret_v_i = 1'b0;
    @(negedge clk);
    check("conf_blocked", {31'd0, w_v_2_o}, 32'd0);
    check("conf_head_addr", {27'd0, w_addr_2_o}, 32'd9);
    check("conf_count", {29'd0, ret_count_o}, 32'd1);
    next_cycle();
    pipe_addr_i = 5'd10;
    @(negedge clk);
    check("conf_release", {31'd0, w_v_2_o}, 32'd1);
    check("conf_rel_addr", {27'd0, w_addr_2_o}, 32'd9);
    next_cycle();
    pipe_v_i = 1'b0;
    wait_empty("conf_drained");

    // x0 drop
    next_cycle();
    ret_v_i = 1'b1; ret_addr_i = 5'd0; ret_data_i = 32'h55;
    @(negedge clk);
    accept_ret("x0_ready");
    next_cycle();
    ret_v_i = 1'b0;
    @(negedge clk);
    check("x0_count", {29'd0, ret_count_o}, 32'd0);
    check("x0_w_v_2", {31'd0, w_v_2_o}, 32'd0);

    // Wrap: 11 back-to-back returns, a brief conflict on addr 30 builds occupancy
    next_cycle();
    for (int i = 0; i < 11; i++) begin
      ret_v_i = 1'b1; ret_addr_i = wrap_addr[i]; ret_data_i = 32'hA000 + 32'(i) * 32'h111;
      pipe_v_i = (i == 7 || i == 8); pipe_addr_i = 5'd30; pipe_data_i = 32'hFFFF;
      @(negedge clk);
      accept_ret("wrap_ready");
      next_cycle();
    end
    ret_v_i = 1'b0; pipe_v_i = 1'b0;
    wait_empty("wrap_drained");
    check("wrap_queue_left", exp_q.size(), 32'd0);

    // Reset mid-stream with three entries parked behind a conflict
    next_cycle();
    pipe_v_i = 1'b1; pipe_addr_i = 5'd6;
    for (int i = 0; i < 3; i++) begin
      ret_v_i = 1'b1; ret_addr_i = 5'd6 + 5'(i); ret_data_i = 32'hC0 + i;
      @(negedge clk);
      accept_ret("mid_ready");
      next_cycle();
    end
    ret_v_i = 1'b0;
    @(negedge clk);
    check("mid_count", {29'd0, ret_count_o}, 32'd3);
    next_cycle();
    reset_i = 1'b1; pipe_v_i = 1'b0;
    @(negedge clk);
    check("mid_rst_w_v_2", {31'd0, w_v_2_o}, 32'd0);
    check("mid_rst_ready", {31'd0, ret_ready_o}, 32'd0);
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk);
    check("post_rst_count", {29'd0, ret_count_o}, 32'd0);
    check("post_rst_w_v_2", {31'd0, w_v_2_o}, 32'd0);
    check("post_rst_empty", {31'd0, ret_empty_o}, 32'd1);
    check("post_rst_ready", {31'd0, ret_ready_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("final_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
